parity_accum_ctrl: RTL

Frame-level controller for the parallel RCE encoder's XOR parity accumulator. It clears the M-bit accumulator at frame start and XORs exactly NBLK accepted parity slices into it under a valid/ready handshake. It then presents the finished parity word downstream with valid/ready back-pressure. It sits between the per-block parity generator (upstream) and the codeword assembler (downstream).

---
 rtl/parity_accum_ctrl_pkg.sv | 15 +
 rtl/parity_xor_acc.sv | 38 +++
 rtl/parity_accum_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/parity_accum_ctrl_pkg.sv
// Shared constants for the RCE parity path: FSM state encoding and default
// slice width / frame length used by the encoder top and the codeword assembler.
package parity_accum_ctrl_pkg;

    localparam int unsigned DEF_M    = 4;
    localparam int unsigned DEF_NBLK = 16;
    localparam int unsigned DEF_CW   = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StOut   = 2'd2
    } state_t;

endpackage

// File: rtl/parity_xor_acc.sv
// M-bit XOR accumulator register: synchronous clear has priority over the
// enable-gated XOR load; asynchronous active-high reset.
module parity_xor_acc
    import parity_accum_ctrl_pkg::*;
#(
    parameter int unsigned M = DEF_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [M-1:0] din,
    output logic [M-1:0] acc
);

    logic [M-1:0] acc_q;
    logic [M-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/parity_accum_ctrl.sv
// Frame controller: clears the accumulator at frame start, XORs NBLK accepted
// slices into it, then offers the parity word downstream under valid/ready.
module parity_accum_ctrl
    import parity_accum_ctrl_pkg::*;
#(
    parameter int unsigned M    = DEF_M,
    parameter int unsigned NBLK = DEF_NBLK,
    parameter int unsigned CW   = DEF_CW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_data,
    output logic         par_valid,
    input  logic         par_ready,
    output logic [M-1:0] par_data,
    output logic         busy,
    output logic         frame_err
);

    localparam logic [CW-1:0] LastBeat = CW'(NBLK - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          acc_clr;
    logic          acc_en;
    logic          beat;

    assign in_ready  = (state_q == StAccum);
    assign par_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign frame_err = err_q;
    assign beat      = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            StAccum: begin
                err_d = start;
                if (beat) begin
                    acc_en = 1'b1;
                    if (cnt_q == LastBeat) begin
                        state_d = StOut;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StOut: begin
                if (par_ready) begin
                    // Start on the handshake cycle chains the next frame with no idle gap.
                    if (start) begin
                        state_d = StAccum;
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    err_d = start;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    parity_xor_acc #(
        .M(M)
    ) u_acc (
        .clk(clk),
        .rst(rst),
        .clr(acc_clr),
        .en (acc_en),
        .din(in_data),
        .acc(par_data)
    );

endmodule
